// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle sequencer for the single-issue NPC core.
// Owns the PC and walks each instruction through fetch request, fetch
// response, one cycle of combinational execute and one write-back cycle.
// Stops with a sticky status code on ebreak, illegal instruction or a fetch
// that never completes.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FETCH_REQ  | request at PC offered to memory until accepted
// FETCH_WAIT | request accepted, waiting for the instruction word
// EXEC       | inst on the datapath, exec_en high, flags sampled at the edge
// WB         | rf_wen high, PC advances (jump target or PC + 4)
// HALT       | absorbing, halt_code held until reset
//
// The first cycle after reset release sits in FETCH_REQ with the request
// still masked (r_live low), so every output reads its reset value during
// and immediately after reset and nothing leaves the block mid-release.

module npc_seq_ctrl #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int unsigned TIMEOUT  = 1024,
   parameter int unsigned CNT_W    = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   output logic [63:0]      ifu_req_addr,
   input  logic             ifu_rsp_valid,
   input  logic [31:0]      ifu_rsp_data,
   output logic [31:0]      inst,
   output logic             exec_en,
   input  logic             exec_ebreak,
   input  logic             exec_illegal,
   input  logic             exec_jump,
   input  logic [63:0]      exec_target,
   output logic             rf_wen,
   output logic             halt,
   output logic [1:0]       halt_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam logic [2:0] ST_FETCH_REQ  = 3'd0;
   localparam logic [2:0] ST_FETCH_WAIT = 3'd1;
   localparam logic [2:0] ST_EXEC       = 3'd2;
   localparam logic [2:0] ST_WB         = 3'd3;
   localparam logic [2:0] ST_HALT       = 3'd4;

   localparam logic [1:0] CODE_RUN     = 2'b00;
   localparam logic [1:0] CODE_EBREAK  = 2'b01;
   localparam logic [1:0] CODE_ILLEGAL = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT = 2'b11;

   // Wide enough to hold TIMEOUT itself; the halt fires before it could wrap.
   localparam int unsigned       TMO_W     = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic             r_live;
   logic [63:0]      r_pc;
   logic [31:0]      r_inst;
   logic             r_jump;
   logic [63:0]      r_target;
   logic [1:0]       r_halt_code;
   logic [1:0]       w_halt_code_nxt;
   logic [TMO_W-1:0] r_tmo;
   logic [TMO_W-1:0] w_tmo_inc;
   logic             w_fetching;
   logic             w_tmo_hit;
   logic             w_retire;
   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_instret;

   // Fetch timeout bookkeeping: one count per live cycle in either fetch state.
   assign w_fetching = r_live && ((r_state == ST_FETCH_REQ) || (r_state == ST_FETCH_WAIT));
   assign w_tmo_inc  = r_tmo + TMO_W'(1);
   assign w_tmo_hit  = w_fetching && (w_tmo_inc == TMO_LIMIT);

   // An ebreak retires (it completed); an illegal instruction does not.
   assign w_retire = ((r_state == ST_EXEC) && exec_ebreak) || (r_state == ST_WB);

   // Next-state and halt-cause selection.
   always_comb begin
      w_state_nxt     = r_state;
      w_halt_code_nxt = r_halt_code;
      case (r_state)
         ST_FETCH_REQ: begin
            if (r_live) begin
               if (w_tmo_hit) begin
                  w_state_nxt     = ST_HALT;
                  w_halt_code_nxt = CODE_TIMEOUT;
               end else if (ifu_req_ready) begin
                  w_state_nxt = ST_FETCH_WAIT;
               end
            end
         end
         ST_FETCH_WAIT: begin
            // A response arriving on the last allowed cycle still wins.
            if (ifu_rsp_valid) begin
               w_state_nxt = ST_EXEC;
            end else if (w_tmo_hit) begin
               w_state_nxt     = ST_HALT;
               w_halt_code_nxt = CODE_TIMEOUT;
            end
         end
         ST_EXEC: begin
            if (exec_ebreak) begin
               w_state_nxt     = ST_HALT;
               w_halt_code_nxt = CODE_EBREAK;
            end else if (exec_illegal) begin
               w_state_nxt     = ST_HALT;
               w_halt_code_nxt = CODE_ILLEGAL;
            end else begin
               w_state_nxt = ST_WB;
            end
         end
         ST_WB: begin
            w_state_nxt = ST_FETCH_REQ;
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_FETCH_REQ;
         end
      endcase
   end

   // State register, release mask, halt code and fetch timeout counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_FETCH_REQ;
         r_live      <= 1'b0;
         r_halt_code <= CODE_RUN;
         r_tmo       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_live      <= 1'b1;
         r_halt_code <= w_halt_code_nxt;
         if (w_state_nxt == ST_EXEC) begin
            r_tmo <= '0;
         end else if (w_fetching) begin
            r_tmo <= w_tmo_inc;
         end
      end
   end

   // Instruction latch, execute-result capture and PC advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_inst   <= '0;
         r_jump   <= 1'b0;
         r_target <= '0;
      end else begin
         if ((r_state == ST_FETCH_WAIT) && ifu_rsp_valid) begin
            r_inst <= ifu_rsp_data;
         end
         if (r_state == ST_EXEC) begin
            r_jump   <= exec_jump;
            r_target <= exec_target;
         end
         // Target bits [1:0] are kept as-is; PC + 4 wraps at 2^64.
         if (r_state == ST_WB) begin
            r_pc <= r_jump ? r_target : (r_pc + 64'd4);
         end
      end
   end

   // Free-running cycle counter (frozen in HALT) and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         if (r_state != ST_HALT) begin
            r_cycle <= r_cycle + CNT_W'(1);
         end
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   assign ifu_req_valid = r_live && (r_state == ST_FETCH_REQ);
   assign ifu_req_addr  = r_pc;
   assign inst          = r_inst;
   assign exec_en       = (r_state == ST_EXEC);
   assign rf_wen        = (r_state == ST_WB);
   assign halt          = (r_state == ST_HALT);
   assign halt_code     = r_halt_code;
   assign cycle_cnt     = r_cycle;
   assign instret_cnt   = r_instret;

endmodule

// File: doc/npc_seq_ctrl.md
Name: npc_seq_ctrl

Overview:
Multi-cycle sequencer for the single-issue NPC core. Owns the PC, fetches instructions over a valid/ready request plus response handshake, presents each instruction to the combinational decode/execute datapath for one cycle, then pulses the register-file write enable. Detects ebreak, illegal instructions and fetch timeouts, and halts with a status code for the simulation harness.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
TIMEOUT, 1024, maximum cycles spent in FETCH_REQ plus FETCH_WAIT for one instruction before an abort halt
CNT_W, 64, width of the cycle and retired-instruction counters

Ports:
clk  in  1  core clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  memory accepts the request
ifu_req_addr  out  64  fetch address, equal to the PC
ifu_rsp_valid  in  1  instruction return valid
ifu_rsp_data  in  32  returned instruction
inst  out  32  latched instruction driven to the decode/execute datapath
exec_en  out  1  high for exactly one cycle while the datapath evaluates inst
exec_ebreak  in  1  datapath flags ebreak (32'h0010_0073)
exec_illegal  in  1  datapath decoded type None for a non-ebreak instruction
exec_jump  in  1  control transfer taken
exec_target  in  64  jump or branch target
rf_wen  out  1  register-file write-enable pulse
halt  out  1  core halted, sticky
halt_code  out  2  00 running, 01 ebreak (good trap), 10 illegal, 11 fetch timeout
cycle_cnt  out  CNT_W  cycles since reset
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async assert, sync deassert at the next edge): state FETCH_REQ, PC = RESET_PC, inst = 0, all 1-bit outputs = 0, halt_code = 00, both counters = 0, timeout counter = 0.
- States: FETCH_REQ, FETCH_WAIT, EXEC, WB, HALT.
- FETCH_REQ: ifu_req_valid = 1 and ifu_req_addr = PC. When ifu_req_ready = 1 in a cycle, go to FETCH_WAIT. ifu_req_valid and ifu_req_addr stay stable until accepted.
- FETCH_WAIT: ifu_req_valid = 0. On ifu_rsp_valid = 1, latch ifu_rsp_data into inst and go to EXEC. ifu_rsp_valid in any other state is ignored.
- Fetch timeout: count cycles spent in FETCH_REQ and FETCH_WAIT. When the count reaches TIMEOUT with no response, go to HALT with code 11. The count clears on entry to EXEC.
- EXEC: exec_en = 1 for one cycle. Sample exec_ebreak, exec_illegal, exec_jump and exec_target at this edge.
  - ebreak: go to HALT with code 01. instret increments; no rf_wen.
  - Illegal (and not ebreak): go to HALT with code 10. No increment, no rf_wen.
  - Otherwise: go to WB.
  - Priority when flags collide: ebreak > illegal.
- WB: rf_wen = 1 for one cycle. PC = exec_target if the jump was taken, else PC + 4 (mod 2^64, wraps silently). instret increments. Go to FETCH_REQ.
- Minimum latency per instruction is 4 cycles: REQ accepted, response in the following cycle, EXEC, WB.
- HALT: absorbing until reset. halt = 1 and halt_code is held. ifu_req_valid, exec_en and rf_wen stay 0. cycle_cnt freezes.
- cycle_cnt increments every cycle while not halted and wraps at 2^CNT_W.
- Reset asserted mid-fetch: the request is abandoned. Any late ifu_rsp_valid after reset is ignored because the state is FETCH_REQ.
- exec_target is not alignment-checked; bits [1:0] pass through to the PC.

Test Plan:
- Reset release, then memory with ready = 1 always and response 1 cycle later; program addi x1,x0,5 then ebreak → first ifu_req_addr = 0x80000000, second = 0x80000004, rf_wen pulses once, halt = 1 with halt_code = 01, instret_cnt = 2, cycle_cnt = 8.
- ifu_req_ready held low for 3 cycles → ifu_req_valid and ifu_req_addr stable throughout, no state advance, then normal completion.
- Response withheld with TIMEOUT = 16 → halt with code 11 exactly 16 cycles after entering FETCH_REQ; instret_cnt = 0.
- Instruction with exec_illegal = 1 → halt with code 10, rf_wen never asserted, PC unchanged.
- exec_jump = 1 with exec_target = 0x80000100 → next ifu_req_addr = 0x80000100; also PC = 0xFFFF_FFFF_FFFF_FFFC with no jump → next address = 0.
- rst_n pulsed low while in FETCH_WAIT, with ifu_rsp_valid arriving after release → outputs return to reset values immediately, the stale response is ignored, and the fetch restarts at RESET_PC.
